bcd_to_bin_seq: RTL and testbench

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd_to_bin_seq.sv | 135 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_NUM_DIGITS = 5;
   localparam int DEF_BIN_W      = 16;
   localparam int DIGIT_W        = 4;
   localparam int ADJ_THRESH     = 8;

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for the reverse double-dabble step: a digit that
// reaches 8 after the right shift had a carry-in of 10 and is pulled back by 3.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q
);

   assign q = (d >= DIGIT_W'(ADJ_THRESH)) ? d - DIGIT_W'(3) : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (shift-right / subtract-3), one bit per clock.
// Optional macro SIGNED_OUT_EN adds sign_in and a two's-complement result.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int BIN_W      = DEF_BIN_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
`ifdef SIGNED_OUT_EN
   input  logic                          sign_in,
`endif
   output logic                          busy,
   output logic                          done,
   output logic [BIN_W-1:0]              bin_out,
   output logic                          ovf,
   output logic                          err
);

   localparam int BCD_W = DIGIT_W * NUM_DIGITS;
   localparam int ITER  = BIN_W + 1;
   localparam int CNT_W = $clog2(ITER + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

   state_t           state, state_nxt;
   logic [BCD_W-1:0] bcd_reg, bcd_shift, bcd_nxt;
   logic [ITER-1:0]  acc, acc_nxt;
   logic [CNT_W-1:0] cnt;
   logic             bad_digit;
   logic             accept;
   logic             last_step;
   logic [BIN_W-1:0] res_val;
   logic             res_ovf;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) bad_digit = 1'b1;
      end
   end

   // One conversion step: {bcd_reg, acc} >> 1, then correct every digit.
   assign bcd_shift = bcd_reg >> 1;
   assign acc_nxt   = {bcd_reg[0], acc[ITER-1:1]};

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d (bcd_shift[g*DIGIT_W +: DIGIT_W]),
         .q (bcd_nxt[g*DIGIT_W +: DIGIT_W])
      );
   end

`ifdef SIGNED_OUT_EN
   logic sign_reg;
   logic mag_hi;

   always_comb begin
      // Magnitude beyond BIN_W bits, regardless of sign.
      mag_hi  = acc_nxt[BIN_W] | (|bcd_nxt);
      res_val = sign_reg ? (~acc_nxt[BIN_W-1:0] + 1'b1) : acc_nxt[BIN_W-1:0];
      if (sign_reg)
         res_ovf = mag_hi | (acc_nxt[BIN_W-1] & (|acc_nxt[BIN_W-2:0]));
      else
         res_ovf = mag_hi | acc_nxt[BIN_W-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         sign_reg <= 1'b0;
      else if (accept) sign_reg <= sign_in;
   end
`else
   always_comb begin
      res_val = acc_nxt[BIN_W-1:0];
      res_ovf = acc_nxt[BIN_W] | (|bcd_nxt);
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_step = 1'b0;
      unique case (state)
         IDLE: if (start) begin
            accept    = 1'b1;
            state_nxt = bad_digit ? DONE : CONV;
         end
         CONV: if (cnt == LAST_STEP) begin
            last_step = 1'b1;
            state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == CONV);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_reg <= '0;
         acc     <= '0;
         cnt     <= '0;
         bin_out <= '0;
         ovf     <= 1'b0;
         err     <= 1'b0;
      end else if (accept) begin
         bcd_reg <= bcd_in;
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         err     <= bad_digit;
         if (bad_digit) bin_out <= '0;
      end else if (busy) begin
         bcd_reg <= bcd_nxt;
         acc     <= acc_nxt;
         cnt     <= cnt + 1'b1;
         if (last_step) begin
            bin_out <= res_val;
            ovf     <= res_ovf;
         end
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq; signed vectors run when SIGNED_OUT_EN is defined.
module tb_bcd_to_bin_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [19:0] bcd_in;
   logic        busy;
   logic        done;
   logic [15:0] bin_out;
   logic        ovf;
   logic        err;
`ifdef SIGNED_OUT_EN
   logic        sign_in;
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   bcd_to_bin_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bcd_in  (bcd_in),
`ifdef SIGNED_OUT_EN
      .sign_in (sign_in),
`endif
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .ovf     (ovf),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge one cycle after the done pulse.
   task automatic run(input string tag, input logic [19:0] bcd, input logic hold,
                      input logic [15:0] exp_bin, input logic exp_ovf,
                      input logic exp_err, input int exp_lat);
      int   lat;
      logic busy_seen;
      bcd_in = bcd;
      start  = 1'b1;
      @(posedge clk);
      #1;
      if (hold) bcd_in = 20'h99999;
      else      start  = 1'b0;
      @(negedge clk);
      lat       = 0;
      busy_seen = busy;
      while (!done && lat < 40) begin
         if (hold && lat == 4) start = 1'b0;
         @(negedge clk);
         lat++;
         busy_seen |= busy;
      end
      start = 1'b0;
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " bin_out"}, bin_out, exp_bin);
      check({tag, " ovf"}, ovf, exp_ovf);
      check({tag, " err"}, err, exp_err);
      check({tag, " busy_seen"}, busy_seen, !exp_err);
      @(negedge clk);
      check({tag, " done_width"}, done, 1'b0);
      check({tag, " idle_busy"}, busy, 1'b0);
      check({tag, " held_bin"}, bin_out, exp_bin);
   endtask

   initial begin
      logic done_seen;
      rst    = 1'b1;
      start  = 1'b0;
      bcd_in = '0;
`ifdef SIGNED_OUT_EN
      sign_in = 1'b0;
`endif
      #3;
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst bin_out", bin_out, 16'h0000);
      check("rst ovf", ovf, 1'b0);
      check("rst err", err, 1'b0);

      // First start lands on the first edge after reset release.
      @(negedge clk);
      rst = 1'b0;
      run("zero",  20'h00000, 1'b0, 16'h0000, 1'b0, 1'b0, 17);
      run("16384", 20'h16384, 1'b0, 16'h4000, 1'b0, 1'b0, 17);
      run("65535", 20'h65535, 1'b1, 16'hFFFF, SGN,  1'b0, 17);
      run("65536", 20'h65536, 1'b0, 16'h0000, 1'b1, 1'b0, 17);
      run("bad",   20'h1A000, 1'b0, 16'h0000, 1'b0, 1'b1, 0);
      run("99999", 20'h99999, 1'b0, 16'h869F, 1'b1, 1'b0, 17);

      // Abort mid-conversion with an asynchronous reset pulse.
      bcd_in = 20'h65535;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort bin_out", bin_out, 16'h0000);
      check("abort ovf", ovf, 1'b0);
      check("abort err", err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         done_seen |= done;
      end
      check("abort no_done", done_seen, 1'b0);
      run("after_abort", 20'h00042, 1'b0, 16'h002A, 1'b0, 1'b0, 17);

`ifdef SIGNED_OUT_EN
      sign_in = 1'b1;
      run("neg128",   20'h00128, 1'b0, 16'hFF80, 1'b0, 1'b0, 17);
      run("neg32768", 20'h32768, 1'b0, 16'h8000, 1'b0, 1'b0, 17);
      run("neg32769", 20'h32769, 1'b0, 16'h7FFF, 1'b1, 1'b0, 17);
      run("neg_zero", 20'h00000, 1'b0, 16'h0000, 1'b0, 1'b0, 17);
      sign_in = 1'b0;
      run("pos32768", 20'h32768, 1'b0, 16'h8000, 1'b1, 1'b0, 17);
      run("pos32767", 20'h32767, 1'b0, 16'h7FFF, 1'b0, 1'b0, 17);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
